// File: rtl/multicycle_control_fsm.sv
// Multicycle MIPS control unit: a Moore FSM that sequences fetch, decode,
// execute, memory and write-back over a shared instruction/data memory.
//
// Parameters:
//   ALUCTL_W      width of alu_control (>= 4); 4-bit codes are zero-extended
//   MEM_HANDSHAKE 1 = memory states wait for mem_ready, 0 = mem_ready ignored
//
// Ports:
//   clk, reset_n              clock (rising edge), async active-low reset
//   opcode, funct             IR[31:26] and IR[5:0]
//   zero                      ALU zero flag, used for beq/bne
//   mem_ready                 memory access completes this cycle
//   pc_en .. zero_ext         datapath enables and mux selects
//   alu_control               ALU operation code
//   instr_retired             one-cycle pulse in each instruction's last state
//   illegal                   sticky illegal-instruction trap flag
//   state                     current state, for debug
module multicycle_control_fsm #(
    parameter int unsigned ALUCTL_W      = 4,
    parameter bit          MEM_HANDSHAKE = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [5:0]          opcode,
    input  logic [5:0]          funct,
    input  logic                zero,
    input  logic                mem_ready,
    output logic                pc_en,
    output logic                iord,
    output logic                mem_read,
    output logic                mem_write,
    output logic                ir_write,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          pc_src,
    output logic                zero_ext,
    output logic [ALUCTL_W-1:0] alu_control,
    output logic                instr_retired,
    output logic                illegal,
    output logic [3:0]          state
);

    localparam int unsigned STATE_W = 4;

    typedef enum logic [STATE_W-1:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BRANCH  = 4'd8,
        IMMEX   = 4'd9,
        IMMWB   = 4'd10,
        JUMP    = 4'd11,
        TRAP    = 4'd12
    } stateT;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1010;

    stateT      stateQ;
    stateT      nextState;
    logic       illegalQ;
    logic       rdy;

    logic       pcEnC;
    logic       iordC;
    logic       memReadC;
    logic       memWriteC;
    logic       irWriteC;
    logic       regDstC;
    logic       memToRegC;
    logic       regWriteC;
    logic       aluSrcAC;
    logic [1:0] aluSrcBC;
    logic [1:0] pcSrcC;
    logic       zeroExtC;
    logic [3:0] aluOpC;
    logic       retireC;

    // Without the handshake every memory access completes in one cycle.
    assign rdy = mem_ready | ~MEM_HANDSHAKE;

    // State register and sticky trap flag.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stateQ   <= FETCH;
            illegalQ <= 1'b0;
        end else begin
            stateQ   <= nextState;
            illegalQ <= illegalQ | (nextState == TRAP);
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        nextState = stateQ;
        pcEnC     = 1'b0;
        iordC     = 1'b0;
        memReadC  = 1'b0;
        memWriteC = 1'b0;
        irWriteC  = 1'b0;
        regDstC   = 1'b0;
        memToRegC = 1'b0;
        regWriteC = 1'b0;
        aluSrcAC  = 1'b0;
        aluSrcBC  = 2'b00;
        pcSrcC    = 2'b00;
        zeroExtC  = 1'b0;
        aluOpC    = ALU_ADD;
        retireC   = 1'b0;

        case (stateQ)
            FETCH: begin
                memReadC = 1'b1;
                aluSrcBC = 2'b01;
                irWriteC = rdy;
                pcEnC    = rdy;
                if (rdy) nextState = DECODE;
            end
            DECODE: begin
                aluSrcBC = 2'b11;
                case (opcode)
                    OP_RTYPE:                   nextState = EXECUTE;
                    OP_LW, OP_SW:               nextState = MEMADR;
                    OP_BEQ, OP_BNE:             nextState = BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ORI:  nextState = IMMEX;
                    OP_J:                       nextState = JUMP;
                    default:                    nextState = TRAP;
                endcase
            end
            MEMADR: begin
                aluSrcAC  = 1'b1;
                aluSrcBC  = 2'b10;
                nextState = (opcode == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iordC    = 1'b1;
                memReadC = 1'b1;
                if (rdy) nextState = MEMWB;
            end
            MEMWB: begin
                memToRegC = 1'b1;
                regWriteC = 1'b1;
                retireC   = 1'b1;
                nextState = FETCH;
            end
            MEMWR: begin
                iordC     = 1'b1;
                memWriteC = 1'b1;
                if (rdy) begin
                    retireC   = 1'b1;
                    nextState = FETCH;
                end
            end
            EXECUTE: begin
                aluSrcAC  = 1'b1;
                nextState = ALUWB;
                case (funct)
                    6'b100000, 6'b100001: aluOpC = ALU_ADD;
                    6'b100010, 6'b100011: aluOpC = ALU_SUB;
                    6'b100100:            aluOpC = ALU_AND;
                    6'b100101:            aluOpC = ALU_OR;
                    6'b101010:            aluOpC = ALU_SLT;
                    6'b000000:            aluOpC = ALU_SLL;
                    default:              nextState = TRAP;
                endcase
            end
            ALUWB: begin
                regDstC   = 1'b1;
                regWriteC = 1'b1;
                retireC   = 1'b1;
                nextState = FETCH;
            end
            BRANCH: begin
                aluSrcAC  = 1'b1;
                aluOpC    = ALU_SUB;
                pcSrcC    = 2'b01;
                pcEnC     = ((opcode == OP_BEQ) & zero) | ((opcode == OP_BNE) & ~zero);
                retireC   = 1'b1;
                nextState = FETCH;
            end
            IMMEX: begin
                aluSrcAC  = 1'b1;
                aluSrcBC  = 2'b10;
                if (opcode == OP_ORI) begin
                    aluOpC   = ALU_OR;
                    zeroExtC = 1'b1;
                end
                nextState = IMMWB;
            end
            IMMWB: begin
                regWriteC = 1'b1;
                retireC   = 1'b1;
                nextState = FETCH;
            end
            JUMP: begin
                pcSrcC    = 2'b10;
                pcEnC     = 1'b1;
                retireC   = 1'b1;
                nextState = FETCH;
            end
            TRAP: begin
                nextState = TRAP;
            end
            default: begin
                nextState = TRAP;
            end
        endcase
    end

    // Enables are held off for as long as reset is asserted.
    assign pc_en         = pcEnC & reset_n;
    assign mem_read      = memReadC & reset_n;
    assign mem_write     = memWriteC & reset_n;
    assign ir_write      = irWriteC & reset_n;
    assign reg_write     = regWriteC & reset_n;
    assign instr_retired = retireC & reset_n;

    assign iord        = iordC;
    assign reg_dst     = regDstC;
    assign mem_to_reg  = memToRegC;
    assign alu_src_a   = aluSrcAC;
    assign alu_src_b   = aluSrcBC;
    assign pc_src      = pcSrcC;
    assign zero_ext    = zeroExtC;
    assign alu_control = ALUCTL_W'(aluOpC);
    assign illegal     = illegalQ;
    assign state       = stateQ;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Self-checking bench for multicycle_control_fsm. Two instances: dut0 with the
// memory handshake and a 4-bit ALU code, dut1 without the handshake and a
// 6-bit ALU code. A per-instruction reference model predicts the state walk
// and every control output each cycle.
module tb_multicycle_control_fsm;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_J   = 6'b000010;

    logic            clk = 1'b0;
    logic            resetN;
    logic [1:0][5:0] opcode;
    logic [1:0][5:0] funct;
    logic [1:0]      zero;
    logic [1:0]      memReady;

    logic [1:0]      pcEn, iord, memRead, memWrite, irWrite, regDst, memToReg;
    logic [1:0]      regWrite, aluSrcA, zeroExt, retired, illegal;
    logic [1:0][1:0] aluSrcB, pcSrc;
    logic [1:0][3:0] st;
    logic [3:0]      aluCtl0;
    logic [5:0]      aluCtl1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_control_fsm #(.ALUCTL_W(4), .MEM_HANDSHAKE(1'b1)) dut0 (
        .clk(clk), .reset_n(resetN), .opcode(opcode[0]), .funct(funct[0]),
        .zero(zero[0]), .mem_ready(memReady[0]), .pc_en(pcEn[0]), .iord(iord[0]),
        .mem_read(memRead[0]), .mem_write(memWrite[0]), .ir_write(irWrite[0]),
        .reg_dst(regDst[0]), .mem_to_reg(memToReg[0]), .reg_write(regWrite[0]),
        .alu_src_a(aluSrcA[0]), .alu_src_b(aluSrcB[0]), .pc_src(pcSrc[0]),
        .zero_ext(zeroExt[0]), .alu_control(aluCtl0), .instr_retired(retired[0]),
        .illegal(illegal[0]), .state(st[0])
    );

    multicycle_control_fsm #(.ALUCTL_W(6), .MEM_HANDSHAKE(1'b0)) dut1 (
        .clk(clk), .reset_n(resetN), .opcode(opcode[1]), .funct(funct[1]),
        .zero(zero[1]), .mem_ready(memReady[1]), .pc_en(pcEn[1]), .iord(iord[1]),
        .mem_read(memRead[1]), .mem_write(memWrite[1]), .ir_write(irWrite[1]),
        .reg_dst(regDst[1]), .mem_to_reg(memToReg[1]), .reg_write(regWrite[1]),
        .alu_src_a(aluSrcA[1]), .alu_src_b(aluSrcB[1]), .pc_src(pcSrc[1]),
        .zero_ext(zeroExt[1]), .alu_control(aluCtl1), .instr_retired(retired[1]),
        .illegal(illegal[1]), .state(st[1])
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bit order: pe io mr mw iw rd m2r rw sa sb[2] ps[2] zx ret ill
    function automatic logic [15:0] obsCtl(input int d);
        return {pcEn[d], iord[d], memRead[d], memWrite[d], irWrite[d], regDst[d],
                memToReg[d], regWrite[d], aluSrcA[d], aluSrcB[d], pcSrc[d],
                zeroExt[d], retired[d], illegal[d]};
    endfunction

    function automatic logic [7:0] obsAlu(input int d);
        return (d == 0) ? 8'(aluCtl0) : 8'(aluCtl1);
    endfunction

    function automatic bit validFunct(input logic [5:0] fn);
        return fn inside {6'b100000, 6'b100001, 6'b100010, 6'b100011,
                          6'b100100, 6'b100101, 6'b101010, 6'b000000};
    endfunction

    // Expected control outputs for a given step of an instruction.
    function automatic logic [15:0] expCtl(input int s, input logic [5:0] op, input bit z, input bit rdy);
        bit pe = 0, io = 0, mr = 0, mw = 0, iw = 0, rd = 0, m2r = 0, rw = 0;
        bit sa = 0, zx = 0, ret = 0, ill = 0;
        logic [1:0] sb = 2'b00, ps = 2'b00;
        case (s)
            0:  begin mr = 1; sb = 2'b01; iw = rdy; pe = rdy; end
            1:  sb = 2'b11;
            2:  begin sa = 1; sb = 2'b10; end
            3:  begin io = 1; mr = 1; end
            4:  begin m2r = 1; rw = 1; ret = 1; end
            5:  begin io = 1; mw = 1; ret = rdy; end
            6:  sa = 1;
            7:  begin rd = 1; rw = 1; ret = 1; end
            8:  begin sa = 1; ps = 2'b01; ret = 1;
                      pe = (op == OP_BEQ && z) || (op == OP_BNE && !z); end
            9:  begin sa = 1; sb = 2'b10; zx = (op == OP_ORI); end
            10: begin rw = 1; ret = 1; end
            11: begin ps = 2'b10; pe = 1; ret = 1; end
            12: ill = 1;
            default: ;
        endcase
        return {pe, io, mr, mw, iw, rd, m2r, rw, sa, sb, ps, zx, ret, ill};
    endfunction

    function automatic logic [7:0] expAlu(input int s, input logic [5:0] op, input logic [5:0] fn);
        logic [7:0] code = 8'h02;
        if (s == 8) code = 8'h06;
        if (s == 9 && op == OP_ORI) code = 8'h01;
        if (s == 6) begin
            case (fn)
                6'b100010, 6'b100011: code = 8'h06;
                6'b100100:            code = 8'h00;
                6'b100101:            code = 8'h01;
                6'b101010:            code = 8'h07;
                6'b000000:            code = 8'h0A;
                default:              code = 8'h02;
            endcase
        end
        return code;
    endfunction

    // Apply reset mid-cycle; both instances must show FETCH with all enables low.
    task automatic doReset();
        logic [15:0] e;
        resetN = 1'b0;
        #1;
        e = expCtl(0, OP_R, 1'b0, 1'b0);
        e[13] = 1'b0;  // mem_read is an enable, forced low in reset
        for (int d = 0; d < 2; d++) begin
            checkVal($sformatf("d%0d reset state", d), 32'(st[d]), 32'd0);
            checkVal($sformatf("d%0d reset ctl", d), 32'(obsCtl(d)), 32'(e));
            checkVal($sformatf("d%0d reset alu", d), 32'(obsAlu(d)), 32'h02);
        end
        @(posedge clk);
        #1;
        checkVal("d0 reset held", 32'(obsCtl(0)), 32'(e));
        @(negedge clk);
        resetN = 1'b1;
    endtask

    // Run one instruction from FETCH, checking each cycle against the model.
    task automatic runInstr(input int d, input logic [5:0] op, input logic [5:0] fn, input bit z,
                            input int readyPct, input int memStall, input int abortAt,
                            output int memWrCycles);
        int  path[$];
        int  s;
        int  stall   = memStall;
        int  retires = 0;
        int  cyc     = 0;
        int  trapCyc = 0;
        bit  rdy;
        bit  hs      = (d == 0);
        bit  done    = 0;
        bit  endedInReset = 0;
        memWrCycles = 0;

        path = {0, 1};
        case (op)
            OP_LW:                         path = {path, 2, 3, 4};
            OP_SW:                         path = {path, 2, 5};
            OP_R:                          path = {path, 6, validFunct(fn) ? 7 : 12};
            OP_BEQ, OP_BNE:                path = {path, 8};
            6'b001000, 6'b001001, OP_ORI:  path = {path, 9, 10};
            OP_J:                          path = {path, 11};
            default:                       path = {path, 12};
        endcase

        opcode[d] = op;
        funct[d]  = fn;
        zero[d]   = z;
        while (!done) begin
            s = path[0];
            if ((s == 3 || s == 5) && stall > 0) begin
                memReady[d] = 1'b0;
                stall--;
            end else begin
                memReady[d] = (int'($urandom_range(0, 99)) < readyPct);
            end
            rdy = memReady[d] || !hs;
            #1;
            checkVal($sformatf("d%0d state", d), 32'(st[d]), 32'(s));
            checkVal($sformatf("d%0d ctl s%0d", d, s), 32'(obsCtl(d)), 32'(expCtl(s, op, z, rdy)));
            checkVal($sformatf("d%0d alu s%0d", d, s), 32'(obsAlu(d)), 32'(expAlu(s, op, fn)));
            if (retired[d]) retires++;
            if (memWrite[d]) memWrCycles++;
            cyc++;
            if (cyc == abortAt) begin
                doReset();
                endedInReset = 1;
                done = 1;
            end else begin
                if (s == 12) begin
                    trapCyc++;
                    if (trapCyc == 3) done = 1;
                end else if (!((s == 0 || s == 3 || s == 5) && !rdy)) begin
                    void'(path.pop_front());
                    if (path.size() == 0) done = 1;
                end
                if (cyc > 300) begin
                    checkVal("timeout", 32'(cyc), 32'd300);
                    done = 1;
                end
                @(negedge clk);
            end
        end

        if (!endedInReset) begin
            if (s == 12) begin
                checkVal($sformatf("d%0d trap retires", d), 32'(retires), 32'd0);
                doReset();
            end else begin
                checkVal($sformatf("d%0d retires", d), 32'(retires), 32'd1);
            end
        end
    endtask

    logic [5:0] legalOps[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                6'b001000, 6'b001001, 6'b001101, 6'b000010};
    logic [5:0] legalFns[8] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011,
                                6'b100100, 6'b100101, 6'b101010, 6'b000000};

    task automatic randomRun(input int d, input int n, input int readyPct);
        int mw;
        logic [5:0] op, fn;
        int abortAt;
        for (int i = 0; i < n; i++) begin
            op = (int'($urandom_range(0, 9)) == 0) ? 6'($urandom) : legalOps[$urandom_range(0, 8)];
            fn = (int'($urandom_range(0, 9)) == 0) ? 6'($urandom) : legalFns[$urandom_range(0, 7)];
            abortAt = (int'($urandom_range(0, 9)) == 0) ? int'($urandom_range(2, 4)) : 0;
            runInstr(d, op, fn, 1'($urandom), readyPct, int'($urandom_range(0, 2)), abortAt, mw);
        end
    endtask

    initial begin
        int mw;
        resetN   = 1'b1;
        opcode   = '0;
        funct    = '0;
        zero     = '0;
        memReady = '0;
        opcode[1] = OP_J;
        @(negedge clk);
        doReset();

        // Handshake instance: directed cases, then random traffic.
        runInstr(0, OP_LW, 6'h00, 1'b0, 100, 0, 0, mw);
        runInstr(0, OP_R, 6'b101010, 1'b0, 100, 0, 0, mw);
        runInstr(0, OP_BNE, 6'h00, 1'b0, 100, 0, 0, mw);
        runInstr(0, OP_BNE, 6'h00, 1'b1, 100, 0, 0, mw);
        runInstr(0, OP_BEQ, 6'h00, 1'b1, 100, 0, 0, mw);
        runInstr(0, OP_SW, 6'h00, 1'b0, 100, 3, 0, mw);
        checkVal("d0 sw stalled mem_write cycles", 32'(mw), 32'd4);
        runInstr(0, OP_ORI, 6'h00, 1'b0, 100, 0, 0, mw);
        runInstr(0, OP_J, 6'h00, 1'b0, 100, 0, 0, mw);
        runInstr(0, 6'b111111, 6'h00, 1'b0, 100, 0, 0, mw);
        runInstr(0, OP_R, 6'b000111, 1'b0, 100, 0, 0, mw);
        runInstr(0, OP_LW, 6'h00, 1'b0, 100, 5, 4, mw);
        randomRun(0, 60, 70);

        // No-handshake, wide ALU code instance.
        memReady[0] = 1'b0;
        opcode[1]   = OP_R;
        funct[1]    = 6'b100000;
        doReset();
        runInstr(1, OP_SW, 6'h00, 1'b0, 0, 0, 0, mw);
        checkVal("d1 sw mem_write cycles", 32'(mw), 32'd1);
        runInstr(1, OP_ORI, 6'h00, 1'b0, 0, 0, 0, mw);
        runInstr(1, OP_LW, 6'h00, 1'b0, 0, 0, 0, mw);
        runInstr(1, OP_R, 6'b000000, 1'b0, 0, 0, 0, mw);
        runInstr(1, OP_BEQ, 6'h00, 1'b1, 0, 0, 0, mw);
        runInstr(1, 6'b010000, 6'h00, 1'b0, 0, 0, 0, mw);
        randomRun(1, 60, 30);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
